qam_carrier_mixer: RTL and testbench

//  Consumes the NCO sin/cos outputs and shaped baseband I/Q; forms IF = I*cos - Q*sin.

---
 rtl/qam_mix_pkg.sv | 20 ++
 rtl/qam_round_sat.sv | 69 ++++++
 rtl/qam_carrier_mixer.sv | 156 +++++++++++++++
 tb/tb_qam_carrier_mixer.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/qam_mix_pkg.sv
// Shared types and default widths for the QAM carrier mixer.
package qam_mix_pkg;

  localparam int QM_MPR      = 10;
  localparam int QM_DW       = 12;
  localparam int QM_OW       = 12;
  localparam int QM_WARM_CYC = 2;

  // Rounding shift, full product width and difference width for the defaults.
  localparam int QM_SH = QM_DW + QM_MPR - QM_OW;
  localparam int QM_PW = QM_DW + QM_MPR;
  localparam int QM_SW = QM_PW + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WARM = 2'd1,
    RUN  = 2'd2
  } qm_state_e;

endpackage

// File: rtl/qam_round_sat.sv
// Final mixer stage: round-half-up shift of the I*cos - Q*sin difference,
// saturation to the output width, and a per-sample clip pulse.
import qam_mix_pkg::*;

module qam_round_sat #(
  parameter int SW = QM_SW,
  parameter int OW = QM_OW,
  parameter int SH = QM_SH
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clken,
  input  logic signed [SW-1:0] sum_i,
  input  logic                 vld_i,
  output logic [OW-1:0]        val_o,
  output logic                 vld_o,
  output logic                 sat_o
);

  // One guard bit so the rounding bias can never wrap.
  localparam int XW = SW + 1;
  localparam logic signed [XW-1:0] BIAS = (SH > 0) ? XW'(64'd1 << (SH - 1)) : '0;
  localparam logic signed [XW-1:0] MAXV = XW'((64'd1 << (OW - 1)) - 64'd1);
  localparam logic signed [XW-1:0] MINV = ~MAXV;

  logic signed [XW-1:0] rnd, shf;
  logic                 hi, lo;
  logic [OW-1:0]        val_q, val_d;
  logic                 vld_q, vld_d;
  logic                 sat_q, sat_d;

  // Round toward +inf at the half point, then detect out-of-range results.
  always_comb begin
    rnd = XW'(sum_i) + BIAS;
    shf = rnd >>> SH;
    hi  = shf > MAXV;
    lo  = shf < MINV;
  end

  // Next output value; the clip pulse only counts for valid samples.
  always_comb begin
    val_d = val_q;
    vld_d = vld_q;
    sat_d = sat_q;
    if (clken) begin
      vld_d = vld_i;
      sat_d = vld_i & (hi | lo);
      val_d = hi ? MAXV[OW-1:0] : (lo ? MINV[OW-1:0] : shf[OW-1:0]);
    end
  end

  // Output register.
  always_ff @(posedge clk) begin
    if (reset) begin
      val_q <= '0;
      vld_q <= 1'b0;
      sat_q <= 1'b0;
    end else begin
      val_q <= val_d;
      vld_q <= vld_d;
      sat_q <= sat_d;
    end
  end

  assign val_o = val_q;
  assign vld_o = vld_q;
  assign sat_o = sat_q;

endmodule

// File: rtl/qam_carrier_mixer.sv
// QAM carrier mixer: IF = I*cos - Q*sin, gated until the NCO has been
// valid for WARM_CYC enabled cycles, 4-stage pipeline, sticky clip flag.
import qam_mix_pkg::*;

module qam_carrier_mixer #(
  parameter int MPR      = QM_MPR,
  parameter int DW       = QM_DW,
  parameter int OW       = QM_OW,
  parameter int WARM_CYC = QM_WARM_CYC
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           clken,
  input  logic           nco_valid,
  input  logic [MPR-1:0] fsin_i,
  input  logic [MPR-1:0] fcos_i,
  input  logic           bb_valid,
  input  logic [DW-1:0]  i_in,
  input  logic [DW-1:0]  q_in,
  input  logic           ovf_clr,
  output logic [OW-1:0]  if_o,
  output logic           if_valid,
  output logic           ovf_o
);

  localparam int PW = DW + MPR;
  localparam int SW = PW + 1;
  localparam int SH = DW + MPR - OW;
  localparam int CW = (WARM_CYC < 1) ? 1 : $clog2(WARM_CYC + 1);

  qm_state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic signed [DW-1:0]  i1_q, i1_d, q1_q, q1_d;
  logic signed [MPR-1:0] s1_q, s1_d, c1_q, c1_d;
  logic signed [PW-1:0]  pic2_q, pic2_d, pqs2_q, pqs2_d;
  logic signed [SW-1:0]  sum3_q, sum3_d;
  // bit0 = S1, bit1 = S2, bit2 = S3; S4 valid lives in the round/sat stage.
  logic [2:0]            vld_pipe_q, vld_pipe_d;
  logic                  ovf_q, ovf_d;
  logic                  inj, sat4;

  // Warm-up FSM: counts consecutive nco_valid cycles before allowing injection.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (clken) begin
      case (state_q)
        IDLE: begin
          if (WARM_CYC == 0) begin
            state_d = RUN;
          end else if (nco_valid) begin
            state_d = (WARM_CYC == 1) ? RUN : WARM;
            cnt_d   = CW'(1);
          end
        end
        WARM: begin
          if (!nco_valid) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
            if (cnt_q + CW'(1) == CW'(WARM_CYC)) state_d = RUN;
          end
        end
        RUN: begin
          if (!nco_valid) begin
            state_d = IDLE;
            cnt_d   = '0;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  assign inj = bb_valid & nco_valid & (state_q == RUN);

  // S1..S3 datapath; baseband is zeroed when absent so the carrier keeps flowing.
  always_comb begin
    i1_d       = i1_q;
    q1_d       = q1_q;
    s1_d       = s1_q;
    c1_d       = c1_q;
    pic2_d     = pic2_q;
    pqs2_d     = pqs2_q;
    sum3_d     = sum3_q;
    vld_pipe_d = vld_pipe_q;
    if (clken) begin
      i1_d       = bb_valid ? i_in : '0;
      q1_d       = bb_valid ? q_in : '0;
      s1_d       = fsin_i;
      c1_d       = fcos_i;
      pic2_d     = PW'(i1_q) * PW'(c1_q);
      pqs2_d     = PW'(q1_q) * PW'(s1_q);
      sum3_d     = SW'(pic2_q) - SW'(pqs2_q);
      vld_pipe_d = {vld_pipe_q[1:0], inj};
    end
  end

  // Sticky clip flag; a new clip beats a simultaneous clear.
  always_comb begin
    ovf_d = ovf_q;
    if (clken) ovf_d = sat4 | (ovf_q & ~ovf_clr);
  end

  // State, counter, pipeline and flag registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      i1_q       <= '0;
      q1_q       <= '0;
      s1_q       <= '0;
      c1_q       <= '0;
      pic2_q     <= '0;
      pqs2_q     <= '0;
      sum3_q     <= '0;
      vld_pipe_q <= '0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      i1_q       <= i1_d;
      q1_q       <= q1_d;
      s1_q       <= s1_d;
      c1_q       <= c1_d;
      pic2_q     <= pic2_d;
      pqs2_q     <= pqs2_d;
      sum3_q     <= sum3_d;
      vld_pipe_q <= vld_pipe_d;
      ovf_q      <= ovf_d;
    end
  end

  qam_round_sat #(
    .SW (SW),
    .OW (OW),
    .SH (SH)
  ) u_rs (
    .clk   (clk),
    .reset (reset),
    .clken (clken),
    .sum_i (sum3_q),
    .vld_i (vld_pipe_q[2]),
    .val_o (if_o),
    .vld_o (if_valid),
    .sat_o (sat4)
  );

  assign ovf_o = ovf_q;

endmodule

// File: tb/tb_qam_carrier_mixer.sv
// Self-checking bench for qam_carrier_mixer against a behavioural model.
import qam_mix_pkg::*;

module tb_qam_carrier_mixer;

  localparam int MPR = 10, DW = 12, OW = 12, WARM_CYC = 2;
  localparam int SH = DW + MPR - OW;

  logic clk = 1'b0, reset = 1'b0, clken = 1'b0, nco_valid = 1'b0, bb_valid = 1'b0, ovf_clr = 1'b0;
  logic [MPR-1:0] fsin_i = '0, fcos_i = '0;
  logic [DW-1:0]  i_in = '0, q_in = '0;
  logic [OW-1:0]  if_o;
  logic           if_valid, ovf_o;

  int tests = 0, fails = 0;

  // Model state: per enabled cycle, was a sample injected, its IF value and clip.
  bit hv[$];
  int hval[$];
  bit hsat[$];
  int streak = 0;
  bit m_ovf = 0;
  bit e_v;
  int e_val;

  qam_carrier_mixer #(.MPR(MPR), .DW(DW), .OW(OW), .WARM_CYC(WARM_CYC)) dut (
    .clk(clk), .reset(reset), .clken(clken), .nco_valid(nco_valid),
    .fsin_i(fsin_i), .fcos_i(fcos_i), .bb_valid(bb_valid),
    .i_in(i_in), .q_in(q_in), .ovf_clr(ovf_clr),
    .if_o(if_o), .if_valid(if_valid), .ovf_o(ovf_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // IF reference: exact integer mix, floor((x + half)/2^SH), clamp.
  function automatic void ref_mix(input int i, input int q, input int s, input int c,
                                  output int val, output bit sat);
    longint sum, t, r;
    sum = longint'(i) * c - longint'(q) * s;
    t   = sum + (longint'(1) << (SH - 1));
    r   = (t >= 0) ? t / (longint'(1) << SH) : -((-t + (longint'(1) << SH) - 1) / (longint'(1) << SH));
    sat = 1'b1;
    if (r > (2 ** (OW - 1)) - 1)   val = (2 ** (OW - 1)) - 1;
    else if (r < -(2 ** (OW - 1))) val = -(2 ** (OW - 1));
    else begin val = int'(r); sat = 1'b0; end
  endfunction

  // One clock: drive, advance the model, compare outputs.
  task automatic step(input bit ce, input bit nv, input bit bv, input int i, input int q,
                      input int s, input int c, input bit clr, input bit rst);
    int v; bit st; int n;
    clken = ce; nco_valid = nv; bb_valid = bv; ovf_clr = clr; reset = rst;
    i_in = DW'(i); q_in = DW'(q); fsin_i = MPR'(s); fcos_i = MPR'(c);
    @(posedge clk);
    #1;
    if (rst) begin
      hv.delete(); hval.delete(); hsat.delete();
      streak = 0; m_ovf = 0;
    end else if (ce) begin
      ref_mix(bv ? i : 0, bv ? q : 0, s, c, v, st);
      hv.push_back(bv && nv && streak >= WARM_CYC);
      hval.push_back(v);
      hsat.push_back(st);
      streak = nv ? streak + 1 : 0;
      n = hv.size();
      if (n >= 5 && hv[n-5] && hsat[n-5]) m_ovf = 1;
      else if (clr) m_ovf = 0;
    end
    n = hv.size();
    e_v = (n >= 4) ? hv[n-4] : 1'b0;
    e_val = (n >= 4) ? hval[n-4] : 0;
    chk("if_valid", 32'(if_valid), 32'(e_v));
    if (e_v) chk("if_o", $signed(if_o), e_val);
    chk("ovf_o", 32'(ovf_o), 32'(m_ovf));
  endtask

  task automatic idle1(input bit nv, input bit clr);
    step(1, nv, 0, 0, 0, 0, 0, clr, 0);
  endtask

  function automatic int rnd(input int lo, input int hi);
    return lo + int'($urandom_range(0, hi - lo));
  endfunction

  initial begin
    int first, zeros;

    // Reset state.
    step(1, 0, 0, 0, 0, 0, 0, 0, 1);
    step(1, 0, 0, 0, 0, 0, 0, 0, 1);
    chk("rst_if_o", $signed(if_o), 0);
    chk("rst_state", 32'(dut.state_q), 32'(IDLE));

    // 1: warm-up with nco_valid from cycle 0; first valid 4 cycles after first injection.
    first = 0;
    for (int k = 1; k <= 10; k++) begin
      step(1, 1, 1, rnd(-100, 100), rnd(-100, 100), rnd(-512, 511), rnd(-512, 511), 0, 0);
      if (k == 2) chk("t1_run", 32'(dut.state_q), 32'(RUN));
      if (if_valid === 1'b1 && first == 0) first = k;
    end
    chk("t1_first_valid", first, 6);

    // 2: plain mixes and round-half-up.
    step(1, 1, 1, 1024, 0, 0, 511, 0, 0);
    step(1, 1, 1, 2, 0, 0, 256, 0, 0);
    step(1, 1, 1, -2, 0, 0, 256, 0, 0);
    idle1(1, 0); chk("t2_511", $signed(if_o), 511);
    idle1(1, 0); chk("t2_one", $signed(if_o), 1);
    idle1(1, 0); chk("t2_half_up", $signed(if_o), 0);
    chk("t2_ovf", 32'(ovf_o), 0);

    // 3: positive saturation, sticky flag, clear, set-beats-clear.
    step(1, 1, 1, -2048, 2047, -512, -512, 0, 0);
    idle1(1, 0); idle1(1, 0); idle1(1, 0);
    chk("t3_sat", $signed(if_o), 2047);
    chk("t3_ovf_late", 32'(ovf_o), 0);
    idle1(1, 0); chk("t3_ovf_set", 32'(ovf_o), 1);
    idle1(1, 0); idle1(1, 0); chk("t3_sticky", 32'(ovf_o), 1);
    idle1(1, 1); chk("t3_clr", 32'(ovf_o), 0);
    step(1, 1, 1, -2048, 2047, -512, -512, 0, 0);
    idle1(1, 0); idle1(1, 0); idle1(1, 0);
    idle1(1, 1); chk("t3_set_wins", 32'(ovf_o), 1);

    // 4: one-cycle nco_valid drop in RUN; gap equals cycles without injection.
    for (int k = 0; k < 3; k++) step(1, 1, 1, rnd(-300, 300), rnd(-300, 300), rnd(-512, 511), rnd(-512, 511), 0, 0);
    zeros = 0;
    for (int k = 0; k < 11; k++) begin
      step(1, (k != 0), 1, rnd(-300, 300), rnd(-300, 300), rnd(-512, 511), rnd(-512, 511), 0, 0);
      if (if_valid !== 1'b1) zeros++;
    end
    chk("t4_gap", zeros, 3);

    // 5: clken toggling with a ramp.
    for (int k = 0; k < 24; k++) step(~k[0], 1, 1, k * 50, k * 10, 100, 300, 0, 0);

    // 6: reset with samples in flight and ovf set.
    step(1, 1, 1, -2048, 2047, -512, -512, 0, 0);
    for (int k = 0; k < 7; k++) step(1, 1, 1, rnd(-200, 200), rnd(-200, 200), rnd(-512, 511), rnd(-512, 511), 0, 0);
    step(1, 1, 1, 5, 5, 5, 5, 0, 1);
    chk("t6_valid", 32'(if_valid), 0);
    chk("t6_if_o", $signed(if_o), 0);
    chk("t6_ovf", 32'(ovf_o), 0);
    chk("t6_state", 32'(dut.state_q), 32'(IDLE));
    for (int k = 0; k < 6; k++) idle1(1, 0);

    // Random traffic.
    for (int k = 0; k < 600; k++)
      step($urandom_range(0, 3) != 0, $urandom_range(0, 9) != 0, $urandom_range(0, 4) != 0,
           rnd(-2048, 2047), rnd(-2048, 2047), rnd(-512, 511), rnd(-512, 511),
           $urandom_range(0, 7) == 0, $urandom_range(0, 99) == 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
